// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer
// Assembles a 16-bit dividend and an 8-bit divisor from a byte stream.
// It rejects divide-by-zero and quotient overflow without using the divider.
// Otherwise it drives op1/op2, waits DIV_LATENCY cycles for the divider and
// then presents the captured quotient with an error code.
module div_operand_sequencer #(
   parameter int DIV_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] op1,
   output logic [7:0]  op2,
   input  logic [7:0]  div_res,
   output logic [7:0]  out_data,
   output logic [1:0]  out_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GOT_HI,
      S_GOT_LO,
      S_CHECK,
      S_WAIT,
      S_OUT
   } state_t;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_OVF  = 2'b10;

   // The counter is loaded with DIV_LATENCY-1 so that WAIT spans DIV_LATENCY edges.
   localparam logic [3:0] LAT_LOAD = 4'(DIV_LATENCY - 1);

   state_t      state_q, state_d;
   logic [15:0] op1_q, op1_d;
   logic [7:0]  op2_q, op2_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [1:0]  out_err_q, out_err_d;
   logic        out_valid_q, out_valid_d;
   logic        accept;

   // Bytes are accepted only in the three assembly states, and never while reset is held.
   assign in_ready = rst & ((state_q == S_IDLE) | (state_q == S_GOT_HI) | (state_q == S_GOT_LO));
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != S_IDLE);

   assign op1       = op1_q;
   assign op2       = op2_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign out_valid = out_valid_q;

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op1_d[15:8] = in_data;
               state_d     = S_GOT_HI;
            end
         end
         S_GOT_HI: begin
            if (accept) begin
               op1_d[7:0] = in_data;
               state_d    = S_GOT_LO;
            end
         end
         S_GOT_LO: begin
            if (accept) begin
               op2_d   = in_data;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (op2_q == 8'h00) begin
               out_data_d  = 8'hFF;
               out_err_d   = ERR_DIV0;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else if (op1_q[15:8] >= op2_q) begin
               // A high byte at or above the divisor means the quotient needs more than 8 bits.
               out_data_d  = 8'hFF;
               out_err_d   = ERR_OVF;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               cnt_d   = LAT_LOAD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               out_data_d  = div_res;
               out_err_d   = ERR_OK;
               out_valid_d = 1'b1;
               state_d     = S_OUT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any partial or pending operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         op1_q       <= 16'h0000;
         op2_q       <= 8'h00;
         cnt_q       <= 4'd0;
         out_data_q  <= 8'h00;
         out_err_q   <= 2'b00;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
